rr_sel_arb4: RTL and testbench

Registered round-robin arbiter for four requesters. It drives the 2-bit select of the 4:1 data-flow mux directly downstream, so one of four sources reaches the mux output at a time. Fairness is guaranteed by a rotating priority pointer. A hold counter caps how long any single requester can keep the grant.

---
 rtl/rr_sel_arb4_pkg.sv | 32 +++
 rtl/rr_sel_arb4_prio_enc4.sv | 19 +
 rtl/rr_sel_arb4.sv | 78 +++++++
 tb/tb_rr_sel_arb4.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rr_sel_arb4_pkg.sv
// Shared types and the rotating-priority pick function for the round-robin arbiter family.
package rr_sel_arb4_pkg;

   localparam int NREQ = 4;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } pick_t;

   // Walk downwards so the index closest to start is the last one written and wins.
   function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [1:0] start);
      pick_t      p;
      logic [1:0] idx;
      p.found = 1'b0;
      p.idx   = 2'd0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = start + 2'(k);
         if (req[idx]) begin
            p.found = 1'b1;
            p.idx   = idx;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/rr_sel_arb4_prio_enc4.sv
// Combinational rotate + priority encode: first set request at or after start, wrapping.
module rr_prio_enc4
   import rr_sel_arb4_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      start,
   output logic            found,
   output logic [1:0]      idx
);

   pick_t pick;

   always_comb begin
      pick  = rr_pick(req, start);
      found = pick.found;
      idx   = pick.idx;
   end

endmodule

// File: rtl/rr_sel_arb4.sv
// Registered 4-way round-robin arbiter driving the select of a 4:1 mux, with a hold-time cap.
module rr_sel_arb4
   import rr_sel_arb4_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CW       = $clog2(MAX_HOLD + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [1:0]      sel,
   output logic            gnt_vld
);

   localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);

   arb_state_t    state, state_nxt;
   logic [1:0]    ptr, ptr_nxt;
   logic [1:0]    sel_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          win_found;
   logic [1:0]    win_idx;
   logic          keep;

   // ptr always equals sel while busy, so one encoder serves both fresh grants and releases.
   rr_prio_enc4 u_enc (
      .req   (req),
      .start (ptr + 2'd1),
      .found (win_found),
      .idx   (win_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= 2'd3;
         sel   <= 2'd0;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         sel   <= sel_nxt;
         cnt   <= cnt_nxt;
      end
   end

   assign keep = (state == BUSY) && req[sel] && (cnt != HOLD_LIM);

   // A release re-arbitrates in the same edge so there is never an idle bubble between grants.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      sel_nxt   = sel;
      cnt_nxt   = cnt;
      if (keep) begin
         cnt_nxt = cnt + CW'(1);
      end else if (win_found) begin
         state_nxt = BUSY;
         ptr_nxt   = win_idx;
         sel_nxt   = win_idx;
         cnt_nxt   = CW'(1);
      end else begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end
   end

   always_comb begin
      gnt     = '0;
      gnt_vld = 1'b0;
      if (state == BUSY) begin
         gnt[sel] = 1'b1;
         gnt_vld  = 1'b1;
      end
   end

endmodule

// File: tb/tb_rr_sel_arb4.sv
// Scoreboard bench for rr_sel_arb4 with MAX_HOLD=8 and MAX_HOLD=1 instances sharing one request bus.
module tb_rr_sel_arb4;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] gnt0, gnt1;
   logic [1:0] sel0, sel1;
   logic       vld0, vld1;
   logic [3:0] mux_i;

   int checks;
   int fails;

   typedef struct {
      logic [3:0] g0;
      logic [1:0] s0;
      logic       v0;
      logic [3:0] g1;
      logic [1:0] s1;
      logic       v1;
      logic       y1;
   } exp_t;

   exp_t sb[$];

   int hold [2];
   int m_last [2];
   int m_holder [2];
   int m_cnt [2];
   int m_sel [2];

   rr_sel_arb4 #(.MAX_HOLD(8)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt0), .sel(sel0), .gnt_vld(vld0)
   );

   rr_sel_arb4 #(.MAX_HOLD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt1), .sel(sel1), .gnt_vld(vld1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic modelReset();
      for (int d = 0; d < 2; d++) begin
         m_last[d]   = 3;
         m_holder[d] = -1;
         m_cnt[d]    = 0;
         m_sel[d]    = 0;
      end
   endtask

   // Reference: holder keeps the grant while requesting and under its cap, otherwise the
   // first requester after the last winner (wrapping back to it last) takes over.
   task automatic modelStep(input logic [3:0] r);
      int w;
      int idx;
      for (int d = 0; d < 2; d++) begin
         if (m_holder[d] >= 0 && r[m_holder[d]] && m_cnt[d] < hold[d]) begin
            m_cnt[d]++;
         end else begin
            w = -1;
            for (int k = 1; k <= 4; k++) begin
               idx = (m_last[d] + k) % 4;
               if (w < 0 && r[idx]) w = idx;
            end
            if (w >= 0) begin
               m_holder[d] = w;
               m_last[d]   = w;
               m_sel[d]    = w;
               m_cnt[d]    = 1;
            end else begin
               m_holder[d] = -1;
               m_cnt[d]    = 0;
            end
         end
      end
   endtask

   task automatic applyStimulus(input logic [3:0] r);
      exp_t e;
      @(negedge clk);
      req = r;
      modelStep(r);
      e.g0 = (m_holder[0] >= 0) ? 4'(1 << m_holder[0]) : 4'b0000;
      e.s0 = 2'(m_sel[0]);
      e.v0 = (m_holder[0] >= 0);
      e.g1 = (m_holder[1] >= 0) ? 4'(1 << m_holder[1]) : 4'b0000;
      e.s1 = 2'(m_sel[1]);
      e.v1 = (m_holder[1] >= 0);
      e.y1 = mux_i[m_sel[1]];
      sb.push_back(e);
   endtask

   // Monitor: every edge with a pending expectation is compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("gnt0", {4'b0, gnt0}, {4'b0, e.g0});
            checkOutput("sel0", {6'b0, sel0}, {6'b0, e.s0});
            checkOutput("vld0", {7'b0, vld0}, {7'b0, e.v0});
            checkOutput("gnt1", {4'b0, gnt1}, {4'b0, e.g1});
            checkOutput("sel1", {6'b0, sel1}, {6'b0, e.s1});
            checkOutput("vld1", {7'b0, vld1}, {7'b0, e.v1});
            checkOutput("mux_y1", {7'b0, mux_i[sel1]}, {7'b0, e.y1});
         end
      end
   end

   initial begin
      logic [3:0] r;
      hold[0] = 8;
      hold[1] = 1;
      mux_i   = 4'b1010;
      checks  = 0;
      fails   = 0;
      rst_n   = 1'b0;
      req     = 4'b0000;
      modelReset();
      repeat (3) @(negedge clk);
      checkOutput("reset_gnt", {4'b0, gnt0}, 8'h00);
      checkOutput("reset_sel", {6'b0, sel0}, 8'h00);
      checkOutput("reset_vld", {7'b0, vld0}, 8'h00);
      rst_n = 1'b1;

      // Single requester then idle; sel must stay parked.
      repeat (3) applyStimulus(4'b0100);
      repeat (3) applyStimulus(4'b0000);
      // Fair rotation with all requesting.
      repeat (40) applyStimulus(4'b1111);
      // Sole requester across several hold caps.
      repeat (20) applyStimulus(4'b0010);
      applyStimulus(4'b0000);
      // Early release with a waiting competitor.
      repeat (2) applyStimulus(4'b1001);
      repeat (3) applyStimulus(4'b1000);
      applyStimulus(4'b0000);

      // Randomised traffic with sticky request patterns.
      r = 4'b0000;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom);
         applyStimulus(r);
      end

      // Asynchronous reset in the middle of a grant.
      repeat (3) applyStimulus(4'b0100);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_gnt", {4'b0, gnt0}, 8'h00);
      checkOutput("midreset_sel", {6'b0, sel0}, 8'h00);
      checkOutput("midreset_vld", {7'b0, vld0}, 8'h00);
      req = 4'b0000;
      modelReset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) applyStimulus(4'b1111);
      applyStimulus(4'b0000);

      @(posedge clk);
      #3;
      checkOutput("sb_drained", 8'(sb.size()), 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
